bcd_rtc_counter: RTL and testbench

// - Parametrised BCD real-time counter: hh:mm:ss, six BCD digits, true 00-59 / 00-23 rollover.
// - Built-in prescaler from system clock to 1 Hz; run/stop control; validated time-load handshake.
// - Runtime 12h/24h display mode with PM flag.
// - Feeds display muxes, timestamping and alarm logic; single clock domain.

---
 rtl/bcd_rtc_counter.sv | 224 ++++++++++++++++++++++
 tb/tb_bcd_rtc_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc_counter.sv
// bcd_rtc_counter
// ---------------------------------------------------------------------------
// BCD real-time counter holding hh:mm:ss as six BCD digits in 24h form.
// A built-in prescaler divides the system clock down to one advance per
// CLK_PER_SEC enabled cycles.
// Time is loaded through a validated single-cycle handshake.
// The hour digits are presented in 24h or 12h form, selected at runtime.
//
// Optional feature: define RTC_ALARM_EN to add an hh:mm alarm comparator.
//
// Parameters
//   CLK_PER_SEC  clock cycles per second advance (1 = every enabled cycle)
//   PS_W         prescaler width, must be >= clog2(CLK_PER_SEC)
// Ports
//   clock                   system clock, rising edge
//   reset_n                 asynchronous active-low reset
//   run                     1 = count, 0 = freeze time and prescaler
//   mode_12h                display mode: 0 = 24h, 1 = 12h
//   load_valid              load request qualifier (one cycle)
//   load_hr/min/sec [7:0]   {tens,units} BCD load value, hours in 24h form
//   load_ack / load_err     one-cycle pulse: load accepted / rejected
//   ms_*/ls_* [3:0]         displayed digits (hours follow mode_12h)
//   pm                      internal hour >= 12
//   sec_pulse               one-cycle pulse per second advance
//   day_wrap                one-cycle pulse on 23:59:59 -> 00:00:00
//   alarm_arm, alarm_hr, alarm_min, alarm_hit   (RTC_ALARM_EN only)
// ---------------------------------------------------------------------------
module bcd_rtc_counter #(
  parameter int CLK_PER_SEC = 1,
  parameter int PS_W        = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load_valid,
  input  logic [7:0] load_hr,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic       load_ack,
  output logic       load_err,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       pm,
  output logic       sec_pulse,
`ifdef RTC_ALARM_EN
  input  logic       alarm_arm,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  output logic       alarm_hit,
`endif
  output logic       day_wrap
);

  localparam int PS_MIN = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);

  generate
    if (CLK_PER_SEC < 1 || PS_W < PS_MIN) begin : g_bad_params
      $error("bcd_rtc_counter: CLK_PER_SEC must be >= 1 and PS_W >= clog2(CLK_PER_SEC)");
    end
  endgenerate

  logic [3:0]      sec_l_q, sec_m_q, min_l_q, min_m_q, hr_l_q, hr_m_q;
  logic [3:0]      sec_l_d, sec_m_d, min_l_d, min_m_d, hr_l_d, hr_m_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic            pulse_q, pulse_d, wrap_q, wrap_d;
  logic            load_ok;

  // Every nibble must be a decimal digit; with that guaranteed, a plain byte
  // compare against 0x23 orders BCD hours correctly.
  assign load_ok = (load_hr[3:0]  <= 4'd9) && (load_hr[7:4]  <= 4'd9) &&
                   (load_min[3:0] <= 4'd9) && (load_min[7:4] <= 4'd5) &&
                   (load_sec[3:0] <= 4'd9) && (load_sec[7:4] <= 4'd5) &&
                   (load_hr <= 8'h23);

  always_comb begin
    sec_l_d = sec_l_q;
    sec_m_d = sec_m_q;
    min_l_d = min_l_q;
    min_m_d = min_m_q;
    hr_l_d  = hr_l_q;
    hr_m_d  = hr_m_q;
    ps_d    = ps_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    pulse_d = 1'b0;
    wrap_d  = 1'b0;
    // Any load request, good or bad, takes priority and suppresses the advance.
    if (load_valid) begin
      if (load_ok) begin
        {hr_m_d, hr_l_d}   = load_hr;
        {min_m_d, min_l_d} = load_min;
        {sec_m_d, sec_l_d} = load_sec;
        ps_d  = '0;
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (run) begin
      if (ps_q == PS_LAST) begin
        ps_d    = '0;
        pulse_d = 1'b1;
        if (sec_l_q != 4'd9) begin
          sec_l_d = sec_l_q + 4'd1;
        end else begin
          sec_l_d = 4'd0;
          if (sec_m_q != 4'd5) begin
            sec_m_d = sec_m_q + 4'd1;
          end else begin
            sec_m_d = 4'd0;
            if (min_l_q != 4'd9) begin
              min_l_d = min_l_q + 4'd1;
            end else begin
              min_l_d = 4'd0;
              if (min_m_q != 4'd5) begin
                min_m_d = min_m_q + 4'd1;
              end else begin
                min_m_d = 4'd0;
                if (hr_m_q == 4'd2 && hr_l_q == 4'd3) begin
                  hr_m_d = 4'd0;
                  hr_l_d = 4'd0;
                  wrap_d = 1'b1;
                end else if (hr_l_q == 4'd9) begin
                  hr_l_d = 4'd0;
                  hr_m_d = hr_m_q + 4'd1;
                end else begin
                  hr_l_d = hr_l_q + 4'd1;
                end
              end
            end
          end
        end
      end else begin
        ps_d = ps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sec_l_q <= 4'd0;
      sec_m_q <= 4'd0;
      min_l_q <= 4'd0;
      min_m_q <= 4'd0;
      hr_l_q  <= 4'd0;
      hr_m_q  <= 4'd0;
      ps_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sec_l_q <= sec_l_d;
      sec_m_q <= sec_m_d;
      min_l_q <= min_l_d;
      min_m_q <= min_m_d;
      hr_l_q  <= hr_l_d;
      hr_m_q  <= hr_m_d;
      ps_q    <= ps_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_hit_q, alarm_hit_d;

  // Only a real advance landing on hh:mm:00 can fire; loads never set pulse_d.
  always_comb begin
    alarm_hit_d = pulse_d && alarm_arm &&
                  (sec_m_d == 4'd0) && (sec_l_d == 4'd0) &&
                  ({hr_m_d, hr_l_d} == alarm_hr) &&
                  ({min_m_d, min_l_d} == alarm_min);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alarm_hit_q <= 1'b0;
    else          alarm_hit_q <= alarm_hit_d;
  end

  assign alarm_hit = alarm_hit_q;
`endif

  // 12h mapping in BCD: 00 -> 12, 13..19 -> 01..07, 20..21 -> 08..09,
  // 22..23 -> 10..11; 01..12 pass through.
  always_comb begin
    ms_hr = hr_m_q;
    ls_hr = hr_l_q;
    if (mode_12h) begin
      if (hr_m_q == 4'd0 && hr_l_q == 4'd0) begin
        ms_hr = 4'd1;
        ls_hr = 4'd2;
      end else if (hr_m_q == 4'd1 && hr_l_q >= 4'd3) begin
        ms_hr = 4'd0;
        ls_hr = hr_l_q - 4'd2;
      end else if (hr_m_q == 4'd2 && hr_l_q <= 4'd1) begin
        ms_hr = 4'd0;
        ls_hr = hr_l_q + 4'd8;
      end else if (hr_m_q == 4'd2) begin
        ms_hr = 4'd1;
        ls_hr = hr_l_q - 4'd2;
      end
    end
  end

  assign pm        = (hr_m_q == 4'd2) || (hr_m_q == 4'd1 && hr_l_q >= 4'd2);
  assign ms_min    = min_m_q;
  assign ls_min    = min_l_q;
  assign ms_sec    = sec_m_q;
  assign ls_sec    = sec_l_q;
  assign load_ack  = ack_q;
  assign load_err  = err_q;
  assign sec_pulse = pulse_q;
  assign day_wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// Directed testbench for bcd_rtc_counter: unit A runs at one advance per
// cycle, unit B at one advance per four cycles.
module tb_bcd_rtc_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_12h = 1'b0;
  logic [7:0] load_hr = 8'h00, load_min = 8'h00, load_sec = 8'h00;

  logic       run_a = 1'b0, lv_a = 1'b0;
  logic       ack_a, err_a, pm_a, pulse_a, wrap_a;
  logic [3:0] mh_a, lh_a, mm_a, lm_a, ms_a, ls_a;

  logic       run_b = 1'b0, lv_b = 1'b0;
  logic       ack_b, err_b, pm_b, pulse_b, wrap_b;
  logic [3:0] mh_b, lh_b, mm_b, lm_b, ms_b, ls_b;

`ifdef RTC_ALARM_EN
  logic       arm_a = 1'b0;
  logic [7:0] al_hr = 8'h00, al_min = 8'h00;
  logic       hit_a, hit_b;
`endif

  int tests  = 0;
  int failed = 0;

  wire [23:0] time_a = {mh_a, lh_a, mm_a, lm_a, ms_a, ls_a};
  wire [23:0] time_b = {mh_b, lh_b, mm_b, lm_b, ms_b, ls_b};

  always #5 clk = ~clk;

  bcd_rtc_counter #(.CLK_PER_SEC(1), .PS_W(1)) u_a (
    .clock(clk), .reset_n(rst_n), .run(run_a), .mode_12h(mode_12h),
    .load_valid(lv_a), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .load_ack(ack_a), .load_err(err_a),
    .ms_hr(mh_a), .ls_hr(lh_a), .ms_min(mm_a), .ls_min(lm_a), .ms_sec(ms_a), .ls_sec(ls_a),
    .pm(pm_a), .sec_pulse(pulse_a),
`ifdef RTC_ALARM_EN
    .alarm_arm(arm_a), .alarm_hr(al_hr), .alarm_min(al_min), .alarm_hit(hit_a),
`endif
    .day_wrap(wrap_a)
  );

  bcd_rtc_counter #(.CLK_PER_SEC(4), .PS_W(2)) u_b (
    .clock(clk), .reset_n(rst_n), .run(run_b), .mode_12h(1'b0),
    .load_valid(lv_b), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
    .load_ack(ack_b), .load_err(err_b),
    .ms_hr(mh_b), .ls_hr(lh_b), .ms_min(mm_b), .ls_min(lm_b), .ms_sec(ms_b), .ls_sec(ls_b),
    .pm(pm_b), .sec_pulse(pulse_b),
`ifdef RTC_ALARM_EN
    .alarm_arm(1'b0), .alarm_hr(8'h00), .alarm_min(8'h00), .alarm_hit(hit_b),
`endif
    .day_wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hr  = h;
    load_min = m;
    load_sec = s;
  endtask

  initial begin
    // ---- reset state ----
    step();
    chk("reset_time_a", time_a, 24'h000000);
    chk("reset_flags_a", {ack_a, err_a, pulse_a, wrap_a, pm_a}, 5'b0);
    chk("reset_time_b", time_b, 24'h000000);
    mode_12h = 1'b1;
    #1;
    chk("reset_12h_display", {time_a, pm_a}, {24'h120000, 1'b0});
    mode_12h = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_pulse", pulse_a, 1'b0);

    // ---- 10 advances at one per cycle ----
    run_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("run_sec_pulse", pulse_a, 1'b1);
    end
    chk("run_10_time", time_a, 24'h000010);
    run_a = 1'b0;
    step();
    chk("stop_no_pulse", {pulse_a, time_a}, {1'b0, 24'h000010});

    // ---- day wrap ----
    set_load(8'h23, 8'h59, 8'h58);
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    chk("load_ack", {ack_a, err_a, pulse_a}, 3'b100);
    chk("load_time", time_a, 24'h235958);
    run_a = 1'b1;
    step();
    chk("adv_235959", {time_a, pulse_a, wrap_a, ack_a}, {24'h235959, 3'b100});
    step();
    chk("adv_wrap", {time_a, pulse_a, wrap_a}, {24'h000000, 2'b11});
    run_a = 1'b0;
    step();
    chk("wrap_once", {wrap_a, pulse_a}, 2'b00);

    // ---- 12h display ----
    mode_12h = 1'b1;
    #1;
    chk("h12_midnight", {time_a, pm_a}, {24'h120000, 1'b0});
    set_load(8'h12, 8'h00, 8'h00);
    lv_a = 1'b1;
    step();
    chk("h12_noon", {time_a, pm_a}, {24'h120000, 1'b1});
    set_load(8'h23, 8'h00, 8'h00);
    step();
    chk("h12_23", {time_a, pm_a}, {24'h110000, 1'b1});
    set_load(8'h20, 8'h00, 8'h00);
    step();
    chk("h12_20", {time_a, pm_a}, {24'h080000, 1'b1});
    set_load(8'h13, 8'h05, 8'h00);
    step();
    lv_a = 1'b0;
    chk("h12_1305", {time_a, pm_a}, {24'h010500, 1'b1});
    mode_12h = 1'b0;
    #1;
    chk("h24_1305", {time_a, pm_a}, {24'h130500, 1'b1});

    // ---- rejected loads ----
    lv_a = 1'b1;
    set_load(8'h24, 8'h00, 8'h00);
    step();
    chk("err_hr24", {err_a, ack_a, time_a}, {2'b10, 24'h130500});
    set_load(8'h10, 8'h60, 8'h00);
    step();
    chk("err_min60", {err_a, ack_a, time_a}, {2'b10, 24'h130500});
    set_load(8'h10, 8'h00, 8'h0A);
    step();
    chk("err_sec0a", {err_a, ack_a, time_a}, {2'b10, 24'h130500});
    lv_a = 1'b0;
    step();
    chk("err_pulse_ends", {err_a, ack_a, time_a}, {2'b00, 24'h130500});

    // ---- load while running wins over the advance ----
    run_a = 1'b1;
    lv_a  = 1'b1;
    set_load(8'h10, 8'h20, 8'h30);
    step();
    lv_a  = 1'b0;
    run_a = 1'b0;
    chk("load_beats_adv", {time_a, pulse_a, ack_a}, {24'h102030, 2'b01});

`ifdef RTC_ALARM_EN
    // ---- alarm ----
    al_hr  = 8'h07;
    al_min = 8'h30;
    arm_a  = 1'b1;
    set_load(8'h07, 8'h30, 8'h00);
    lv_a = 1'b1;
    step();
    chk("alarm_not_on_load", hit_a, 1'b0);
    set_load(8'h07, 8'h29, 8'h59);
    step();
    lv_a  = 1'b0;
    run_a = 1'b1;
    step();
    chk("alarm_hit", {time_a, hit_a, pulse_a}, {24'h073000, 2'b11});
    step();
    run_a = 1'b0;
    chk("alarm_once", hit_a, 1'b0);
    arm_a = 1'b0;
    lv_a  = 1'b1;
    step();
    lv_a  = 1'b0;
    run_a = 1'b1;
    step();
    run_a = 1'b0;
    chk("alarm_disarmed", {time_a, hit_a}, {24'h073000, 1'b0});
`endif

    // ---- reset mid-load drops the pending ack ----
    set_load(8'h01, 8'h02, 8'h03);
    lv_a = 1'b1;
    step();
    lv_a = 1'b0;
    chk("pre_reset_ack", ack_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {time_a, ack_a}, {24'h000000, 1'b0});
    step();
    rst_n = 1'b1;

    // ---- prescaler of 4 on unit B ----
    run_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ps4_no_pulse", {pulse_b, time_b}, {1'b0, 24'h000000});
    end
    step();
    chk("ps4_adv", {pulse_b, time_b}, {1'b1, 24'h000001});
    step();
    step();
    chk("ps4_mid", pulse_b, 1'b0);
    run_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ps4_frozen", {pulse_b, time_b}, {1'b0, 24'h000001});
    end
    run_b = 1'b1;
    step();
    chk("ps4_resume", pulse_b, 1'b0);
    step();
    chk("ps4_phase", {pulse_b, time_b}, {1'b1, 24'h000002});
    step();
    step();
    step();
    chk("ps4_pre_load", pulse_b, 1'b0);
    set_load(8'h05, 8'h06, 8'h07);
    lv_b = 1'b1;
    step();
    lv_b = 1'b0;
    chk("ps4_load_on_adv", {time_b, pulse_b, ack_b}, {24'h050607, 2'b01});
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ps4_after_load", pulse_b, 1'b0);
    end
    step();
    chk("ps4_adv_after_load", {pulse_b, time_b}, {1'b1, 24'h050608});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
